traffic_light_ctrl: RTL and testbench

//  Sequencer for a two-way (NS/EW) intersection. Derives a 1 s tick from CLK,

---
 rtl/traffic_light_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_ctrl.sv
// Two-way (NS/EW) intersection sequencer: 1 s prescaler, 6-state light FSM, countdown display.
// Optional pedestrian request/walk feature is compiled in with `define PED_REQ_EN.
module traffic_light_ctrl #(
  parameter int CLK_FREQ      = 50_000_000,
  parameter int GREEN_T       = 30,
  parameter int YELLOW_T      = 3,
  parameter int ALLRED_T      = 2,
  parameter int PED_GREEN_MIN = 5
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       Pause,
  output logic [2:0] NS_Light,
  output logic [2:0] EW_Light,
  output logic [7:0] Number_Data,
  output logic       Sec_Tick,
`ifdef PED_REQ_EN
  input  logic       Ped_Req,
  output logic       Ped_Walk,
`endif
  output logic [2:0] o_dbg_state
);

  localparam int PW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_FREQ - 1);

  localparam logic [7:0] GREEN_8   = 8'(GREEN_T);
  localparam logic [7:0] YELLOW_8  = 8'(YELLOW_T);
  localparam logic [7:0] ALLRED_8  = 8'(ALLRED_T);
  localparam logic [7:0] PED_MIN_8 = 8'(PED_GREEN_MIN);

  localparam logic [2:0] S_NS_G = 3'd0;
  localparam logic [2:0] S_NS_Y = 3'd1;
  localparam logic [2:0] S_AR1  = 3'd2;
  localparam logic [2:0] S_EW_G = 3'd3;
  localparam logic [2:0] S_EW_Y = 3'd4;
  localparam logic [2:0] S_AR2  = 3'd5;

  localparam logic [2:0] LAMP_R = 3'b100;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_G = 3'b001;

  function automatic logic [2:0] f_next(input logic [2:0] s);
    case (s)
      S_NS_G:  f_next = S_NS_Y;
      S_NS_Y:  f_next = S_AR1;
      S_AR1:   f_next = S_EW_G;
      S_EW_G:  f_next = S_EW_Y;
      S_EW_Y:  f_next = S_AR2;
      default: f_next = S_NS_G;
    endcase
  endfunction

  function automatic logic [7:0] f_dur(input logic [2:0] s);
    case (s)
      S_NS_G, S_EW_G: f_dur = GREEN_8;
      S_NS_Y, S_EW_Y: f_dur = YELLOW_8;
      default:        f_dur = ALLRED_8;
    endcase
  endfunction

  function automatic logic [2:0] f_ns_lamp(input logic [2:0] s);
    case (s)
      S_NS_G:  f_ns_lamp = LAMP_G;
      S_NS_Y:  f_ns_lamp = LAMP_Y;
      default: f_ns_lamp = LAMP_R;
    endcase
  endfunction

  function automatic logic [2:0] f_ew_lamp(input logic [2:0] s);
    case (s)
      S_EW_G:  f_ew_lamp = LAMP_G;
      S_EW_Y:  f_ew_lamp = LAMP_Y;
      default: f_ew_lamp = LAMP_R;
    endcase
  endfunction

  logic [PW-1:0] r_presc;
  logic [2:0]    r_state;
  logic [7:0]    r_cnt;
  logic [2:0]    r_ns_light;
  logic [2:0]    r_ew_light;
  logic          r_tick;

  logic [PW-1:0] w_presc_nxt;
  logic [2:0]    w_state_nxt;
  logic [7:0]    w_cnt_nxt;
  logic          w_wrap;
  logic          w_legal;
  logic          w_adv;
  logic          w_is_green;
  logic          w_ped_any;
  logic          w_ped_load;

  // Countdown steps and state advances happen on the wrap edge itself, so the
  // new value and the Sec_Tick pulse appear together in the following cycle.
  always_comb begin
    w_wrap      = !Pause && (r_presc == PRESC_MAX);
    w_presc_nxt = r_presc;
    if (!Pause) begin
      w_presc_nxt = w_wrap ? '0 : r_presc + 1'b1;
    end
    w_legal    = (r_state <= S_AR2);
    w_adv      = w_legal && w_wrap && (r_cnt <= 8'd1);
    w_is_green = (r_state == S_NS_G) || (r_state == S_EW_G);
    w_ped_load = w_ped_any && !Pause && w_is_green && (r_cnt > PED_MIN_8);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!w_legal) begin
      w_state_nxt = S_NS_G;
      w_cnt_nxt   = GREEN_8;
    end else if (w_ped_load) begin
      // A pedestrian truncation wins over a coincident tick.
      w_cnt_nxt = PED_MIN_8;
    end else if (w_adv) begin
      w_state_nxt = f_next(r_state);
      w_cnt_nxt   = f_dur(f_next(r_state));
    end else if (w_wrap) begin
      w_cnt_nxt = r_cnt - 8'd1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_presc    <= '0;
      r_state    <= S_NS_G;
      r_cnt      <= GREEN_8;
      r_ns_light <= LAMP_G;
      r_ew_light <= LAMP_R;
      r_tick     <= 1'b0;
    end else begin
      r_presc    <= w_presc_nxt;
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_ns_light <= f_ns_lamp(w_state_nxt);
      r_ew_light <= f_ew_lamp(w_state_nxt);
      r_tick     <= w_wrap;
    end
  end

`ifdef PED_REQ_EN
  logic r_ped_pending;
  logic r_ped_walk;
  logic w_enter_ar;
  logic w_pend_nxt;
  logic w_walk_nxt;

  // A request seen on the same edge that enters all-red is served by that walk.
  always_comb begin
    w_ped_any  = r_ped_pending | Ped_Req;
    w_enter_ar = w_adv && ((w_state_nxt == S_AR1) || (w_state_nxt == S_AR2));
    w_walk_nxt = r_ped_walk;
    if (w_enter_ar) begin
      w_walk_nxt = w_ped_any;
    end else if (w_adv || !w_legal) begin
      w_walk_nxt = 1'b0;
    end
    w_pend_nxt = r_ped_pending;
    if (w_enter_ar && w_ped_any) begin
      w_pend_nxt = 1'b0;
    end else if (Ped_Req) begin
      w_pend_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ped_pending <= 1'b0;
      r_ped_walk    <= 1'b0;
    end else begin
      r_ped_pending <= w_pend_nxt;
      r_ped_walk    <= w_walk_nxt;
    end
  end

  assign Ped_Walk = r_ped_walk;
`else
  assign w_ped_any = 1'b0;
`endif

  assign NS_Light    = r_ns_light;
  assign EW_Light    = r_ew_light;
  assign Number_Data = r_cnt;
  assign Sec_Tick    = r_tick;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl with a fast prescaler (4 CLK per second).
module tb_traffic_light_ctrl;

  localparam int CLK_FREQ      = 4;
  localparam int GREEN_T       = 6;
  localparam int YELLOW_T      = 2;
  localparam int ALLRED_T      = 1;
  localparam int PED_GREEN_MIN = 2;

  localparam logic [2:0] R = 3'b100;
  localparam logic [2:0] Y = 3'b010;
  localparam logic [2:0] G = 3'b001;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       Pause = 1'b0;
  logic [2:0] NS_Light;
  logic [2:0] EW_Light;
  logic [7:0] Number_Data;
  logic       Sec_Tick;
  logic [2:0] dbg_state;
`ifdef PED_REQ_EN
  logic       Ped_Req = 1'b0;
  logic       Ped_Walk;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [13:0] exp_q[$];

  typedef struct {
    logic       pause;
    int         gap;
    logic [7:0] nd;
    logic [2:0] ns;
    logic [2:0] ew;
  } vec_t;

  vec_t vecs[18];

  traffic_light_ctrl #(
    .CLK_FREQ(CLK_FREQ), .GREEN_T(GREEN_T), .YELLOW_T(YELLOW_T),
    .ALLRED_T(ALLRED_T), .PED_GREEN_MIN(PED_GREEN_MIN)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .Pause(Pause),
    .NS_Light(NS_Light),
    .EW_Light(EW_Light),
    .Number_Data(Number_Data),
    .Sec_Tick(Sec_Tick),
`ifdef PED_REQ_EN
    .Ped_Req(Ped_Req),
    .Ped_Walk(Ped_Walk),
`endif
    .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input string name, input logic [7:0] nd,
                           input logic [2:0] ns, input logic [2:0] ew);
    check(name, {18'b0, Number_Data, NS_Light, EW_Light}, {18'b0, nd, ns, ew});
  endtask

  task automatic check_safe();
    logic ok;
    ok = $onehot(NS_Light) && $onehot(EW_Light) && ((NS_Light == R) || (EW_Light == R));
    check("lamp_safe", {31'b0, ok}, 32'd1);
  endtask

  // Steps negedge by negedge until Sec_Tick is seen; cyc is the CLK count taken.
  task automatic wait_tick(output int cyc);
    cyc = 0;
    do begin
      @(negedge CLK);
      cyc++;
      check_safe();
    end while (!Sec_Tick && cyc < 40);
    if (!Sec_Tick) check("tick_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    Pause = 1'b0;
    @(negedge CLK);
    check_out("reset_out", 8'd6, G, R);
    check("reset_tick", {31'b0, Sec_Tick}, 32'd0);
    check("reset_state", {29'b0, dbg_state}, 32'd0);
`ifdef PED_REQ_EN
    check("reset_walk", {31'b0, Ped_Walk}, 32'd0);
`endif
    RST = 1'b0;
  endtask

  initial begin
    int cyc;
    logic found;
    logic [13:0] exp;

    vecs[0]  = '{1'b0, 4, 8'd5, G, R};
    vecs[1]  = '{1'b0, 4, 8'd4, G, R};
    vecs[2]  = '{1'b0, 4, 8'd3, G, R};
    vecs[3]  = '{1'b0, 4, 8'd2, G, R};
    vecs[4]  = '{1'b0, 4, 8'd1, G, R};
    vecs[5]  = '{1'b0, 4, 8'd2, Y, R};
    vecs[6]  = '{1'b0, 4, 8'd1, Y, R};
    vecs[7]  = '{1'b0, 4, 8'd1, R, R};
    vecs[8]  = '{1'b0, 4, 8'd6, R, G};
    vecs[9]  = '{1'b0, 4, 8'd5, R, G};
    vecs[10] = '{1'b0, 4, 8'd4, R, G};
    vecs[11] = '{1'b0, 4, 8'd3, R, G};
    vecs[12] = '{1'b0, 4, 8'd2, R, G};
    vecs[13] = '{1'b0, 4, 8'd1, R, G};
    vecs[14] = '{1'b0, 4, 8'd2, R, Y};
    vecs[15] = '{1'b0, 4, 8'd1, R, Y};
    vecs[16] = '{1'b0, 4, 8'd1, R, R};
    vecs[17] = '{1'b0, 4, 8'd6, G, R};

    do_reset();

    // Full cycle: one record per tick, spacing and display/lamps per second
    foreach (vecs[i]) exp_q.push_back({vecs[i].nd, vecs[i].ns, vecs[i].ew});
    foreach (vecs[i]) begin
      Pause = vecs[i].pause;
      wait_tick(cyc);
      check($sformatf("cycle_gap_%0d", i), cyc, vecs[i].gap);
      exp = exp_q.pop_front();
      check($sformatf("cycle_tick_%0d", i), {18'b0, Number_Data, NS_Light, EW_Light}, {18'b0, exp});
    end

    // Pause at NS_G, Number_Data=4, prescaler mid-count
    wait_tick(cyc);
    check_out("pre_pause_5", 8'd5, G, R);
    wait_tick(cyc);
    check_out("pre_pause_4", 8'd4, G, R);
    repeat (2) @(negedge CLK);
    Pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      check_out("pause_hold", 8'd4, G, R);
      check("pause_no_tick", {31'b0, Sec_Tick}, 32'd0);
    end
    Pause = 1'b0;
    wait_tick(cyc);
    check("resume_gap", cyc, 32'd2);
    check_out("resume_val", 8'd3, G, R);

    // Run into EW_Y, then reset mid-sequence
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      wait_tick(cyc);
      if (EW_Light == Y) found = 1'b1;
    end
    check("reach_ew_y", {31'b0, found}, 32'd1);
    check_out("ew_y_entry", 8'd2, R, Y);
    RST = 1'b1;
    @(negedge CLK);
    check_out("mid_reset", 8'd6, G, R);
    check("mid_reset_state", {29'b0, dbg_state}, 32'd0);
    check("mid_reset_tick", {31'b0, Sec_Tick}, 32'd0);
    RST = 1'b0;
    wait_tick(cyc);
    check("post_reset_gap", cyc, 32'd4);
    check_out("post_reset_val", 8'd5, G, R);

`ifdef PED_REQ_EN
    // Request coincident with a tick at NS_G=5: truncation beats decrement
    repeat (3) @(negedge CLK);
    check_out("ped_pre", 8'd5, G, R);
    Ped_Req = 1'b1;
    @(negedge CLK);
    Ped_Req = 1'b0;
    check_out("ped_load", 8'd2, G, R);
    check("ped_load_tick", {31'b0, Sec_Tick}, 32'd1);
    wait_tick(cyc);
    check("ped_gap", cyc, 32'd4);
    check_out("ped_ns_g_1", 8'd1, G, R);
    wait_tick(cyc);
    check_out("ped_ns_y_2", 8'd2, Y, R);
    check("ped_walk_ns_y", {31'b0, Ped_Walk}, 32'd0);
    wait_tick(cyc);
    check_out("ped_ns_y_1", 8'd1, Y, R);
    wait_tick(cyc);
    check_out("ped_ar1", 8'd1, R, R);
    check("ped_walk_ar1", {31'b0, Ped_Walk}, 32'd1);
    repeat (2) @(negedge CLK);
    check("ped_walk_ar1_hold", {31'b0, Ped_Walk}, 32'd1);
    wait_tick(cyc);
    check_out("ped_ew_g", 8'd6, R, G);
    check("ped_walk_ew_g", {31'b0, Ped_Walk}, 32'd0);
    @(negedge CLK);
    check_out("ped_ew_g_noload", 8'd6, R, G);

    // Request at EW_G=2: no truncation, walk in AR2 only
    for (int k = 0; k < 4; k++) wait_tick(cyc);
    check_out("ped2_ew_g_2", 8'd2, R, G);
    Ped_Req = 1'b1;
    @(negedge CLK);
    Ped_Req = 1'b0;
    check_out("ped2_no_reload", 8'd2, R, G);
    wait_tick(cyc);
    check_out("ped2_ew_g_1", 8'd1, R, G);
    wait_tick(cyc);
    check_out("ped2_ew_y_2", 8'd2, R, Y);
    check("ped2_walk_ew_y", {31'b0, Ped_Walk}, 32'd0);
    wait_tick(cyc);
    wait_tick(cyc);
    check_out("ped2_ar2", 8'd1, R, R);
    check("ped2_walk_ar2", {31'b0, Ped_Walk}, 32'd1);
    wait_tick(cyc);
    check_out("ped2_ns_g", 8'd6, G, R);
    check("ped2_walk_ns_g", {31'b0, Ped_Walk}, 32'd0);
    @(negedge CLK);
    check_out("ped2_ns_g_noload", 8'd6, G, R);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
